// File: rtl/mem_arbiter.sv
// Two-port line-wide memory arbiter: dcache (port 0) and icache (port 1) share one
// memory, one whole-line transaction at a time, round-robin, with a turnaround cycle and ack watchdog.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic [LINE_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [1:0]       state;
  logic [1:0]       grant;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  logic             pick;

  // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
  assign pick = p1_enable_i & (~p0_enable_i | ~last);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      grant   <= 2'b00;
      last    <= 1'b1;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (p0_enable_i | p1_enable_i) begin
            grant <= pick ? 2'b10 : 2'b01;
            last  <= pick;
            cnt   <= '0;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (mem_ack_i) begin
            grant <= 2'b00;
            state <= S_TURN;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            grant   <= 2'b00;
            state   <= S_TURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TURN:  state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  assign mem_enable_o = (state == S_GRANT);

  // Request fields follow the owner's live inputs, even if it drops enable mid-transaction.
  always_comb begin
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    if (mem_enable_o) begin
      if (grant[1]) begin
        mem_write_o = p1_write_i;
        mem_addr_o  = p1_addr_i;
        mem_data_o  = p1_data_i;
      end else begin
        mem_write_o = p0_write_i;
        mem_addr_o  = p0_addr_i;
        mem_data_o  = p0_data_i;
      end
    end
  end

  assign p0_ack_o  = mem_enable_o & grant[0] & mem_ack_i;
  assign p1_ack_o  = mem_enable_o & grant[1] & mem_ack_i;
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;
  assign grant_o   = grant;
  assign timeout_o = timeout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the bench plays the memory and both caches.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
  logic [ADDR_W-1:0] p0_addr_i, p1_addr_i, mem_addr_o;
  logic [LINE_W-1:0] p0_data_i, p1_data_i, p0_data_o, p1_data_o, mem_data_o, mem_data_i;
  logic              p0_ack_o, p1_ack_o, mem_enable_o, mem_write_o, mem_ack_i, timeout_o;
  logic [1:0]        grant_o;

  int checks = 0;
  int errors = 0;

  logic [LINE_W-1:0] pat_a, pat_b, pat_w;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'h5A5A_0002}};
    pat_w = {8{32'hDEAD_BEEF}};
    rst_i = 1'b0;
    p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
    p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
    mem_data_i = '0; mem_ack_i = 0;
    tick(); tick();
    check("rst_grant", grant_o, 2'b00);
    check("rst_men", mem_enable_o, 1'b0);
    check("rst_mwr", mem_write_o, 1'b0);
    check("rst_maddr", mem_addr_o, '0);
    check("rst_mdata", mem_data_o, '0);
    check("rst_acks", {p1_ack_o, p0_ack_o}, 2'b00);
    check("rst_tmo", timeout_o, 1'b0);
    rst_i = 1'b1;
    tick();

    // single read by port 0, memory answers after 5 granted cycles
    p0_enable_i = 1; p0_write_i = 0; p0_addr_i = 32'h400;
    #1 check("rd_men_pre", mem_enable_o, 1'b0);
    tick();
    check("rd_grant", grant_o, 2'b01);
    check("rd_men", mem_enable_o, 1'b1);
    check("rd_addr", mem_addr_o, 32'h400);
    check("rd_wr", mem_write_o, 1'b0);
    repeat (4) tick();
    check("rd_noack", p0_ack_o, 1'b0);
    mem_ack_i = 1; mem_data_i = pat_a;
    #1;
    check("rd_p0ack", p0_ack_o, 1'b1);
    check("rd_p1ack", p1_ack_o, 1'b0);
    check("rd_p0data", p0_data_o, pat_a);
    check("rd_p1data", p1_data_o, pat_a);
    tick();
    mem_ack_i = 0; p0_enable_i = 0;
    check("rd_turn_men", mem_enable_o, 1'b0);
    check("rd_turn_grant", grant_o, 2'b00);
    tick();
    check("rd_idle_men", mem_enable_o, 1'b0);

    // simultaneous after reset: p0 write-back goes first
    rst_i = 0; tick(); rst_i = 1; tick();
    p0_enable_i = 1; p0_write_i = 1; p0_addr_i = 32'h800; p0_data_i = pat_w;
    p1_enable_i = 1; p1_write_i = 0; p1_addr_i = 32'h40;  p1_data_i = pat_b;
    tick();
    check("sim_grant0", grant_o, 2'b01);
    check("sim_wr0", mem_write_o, 1'b1);
    check("sim_addr0", mem_addr_o, 32'h800);
    check("sim_data0", mem_data_o, pat_w);
    mem_ack_i = 1;
    #1;
    check("sim_acks0", {p1_ack_o, p0_ack_o}, 2'b01);
    tick();
    mem_ack_i = 0; p0_enable_i = 0; p0_write_i = 0;
    check("sim_turn_men", mem_enable_o, 1'b0);
    tick();
    check("sim_idle_grant", grant_o, 2'b00);
    tick();
    check("sim_grant1", grant_o, 2'b10);
    check("sim_addr1", mem_addr_o, 32'h40);
    check("sim_wr1", mem_write_o, 1'b0);
    check("sim_data1", mem_data_o, pat_b);
    mem_ack_i = 1;
    #1;
    check("sim_acks1", {p1_ack_o, p0_ack_o}, 2'b10);
    tick();
    mem_ack_i = 0;
    tick();

    // fairness: both hold requests; last grant was port 1
    p0_enable_i = 1; p1_enable_i = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("fair_grant%0d", i), grant_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      mem_ack_i = 1;
      tick();
      mem_ack_i = 0;
      tick();
    end
    p0_enable_i = 0; p1_enable_i = 0;

    // stray acks in IDLE and TURN
    mem_ack_i = 1;
    #1;
    check("stray_idle_acks", {p1_ack_o, p0_ack_o}, 2'b00);
    tick();
    check("stray_idle_grant", grant_o, 2'b00);
    check("stray_idle_men", mem_enable_o, 1'b0);
    mem_ack_i = 0;
    p0_enable_i = 1;
    tick();
    mem_ack_i = 1;
    tick();
    p0_enable_i = 0;
    #1;
    check("stray_turn_acks", {p1_ack_o, p0_ack_o}, 2'b00);
    tick();
    mem_ack_i = 0;
    check("stray_back_idle", {grant_o, mem_enable_o}, 3'b000);

    // mid-transaction drop: ack still reaches the port
    p0_enable_i = 1; p0_addr_i = 32'hC00;
    tick();
    p0_enable_i = 0;
    tick();
    check("drop_men", mem_enable_o, 1'b1);
    check("drop_grant", grant_o, 2'b01);
    mem_ack_i = 1;
    #1;
    check("drop_ack", p0_ack_o, 1'b1);
    tick();
    mem_ack_i = 0;
    tick();

    // watchdog: 8 granted cycles without ack
    p1_enable_i = 1; p1_addr_i = 32'h80;
    tick();
    check("wd_grant", grant_o, 2'b10);
    repeat (7) tick();
    check("wd_still_grant", grant_o, 2'b10);
    check("wd_tmo_pre", timeout_o, 1'b0);
    tick();
    check("wd_tmo", timeout_o, 1'b1);
    check("wd_grant_clr", grant_o, 2'b00);
    check("wd_men", mem_enable_o, 1'b0);
    check("wd_noack", p1_ack_o, 1'b0);
    p1_enable_i = 0;
    tick();
    p0_enable_i = 1;
    tick();
    check("wd_next_grant", grant_o, 2'b01);
    mem_ack_i = 1;
    #1;
    check("wd_next_ack", p0_ack_o, 1'b1);
    tick();
    mem_ack_i = 0; p0_enable_i = 0;
    check("wd_sticky", timeout_o, 1'b1);
    tick();

    // reset while port 1 is granted
    p1_enable_i = 1;
    tick();
    check("mr_grant", grant_o, 2'b10);
    rst_i = 0;
    #1;
    check("mr_men", mem_enable_o, 1'b0);
    check("mr_grant_clr", grant_o, 2'b00);
    check("mr_tmo", timeout_o, 1'b0);
    tick();
    rst_i = 1; p0_enable_i = 1;
    tick();
    check("mr_p0_first", grant_o, 2'b01);
    mem_ack_i = 1;
    tick();
    mem_ack_i = 0; p0_enable_i = 0;
    tick();
    tick();
    check("mr_p1_next", grant_o, 2'b10);
    mem_ack_i = 1;
    #1;
    check("mr_p1_ack", p1_ack_o, 1'b1);
    tick();
    mem_ack_i = 0; p1_enable_i = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
